// File: rtl/ahb_lite_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ahb_lite_bus_arbiter
// Brief   : Two-master AHB-Lite arbiter with address/data multiplexer. Define
//           AHB_ARB_FIXED_PRIO_EN for fixed priority (master 0 wins ties).
// Revision: 1.0 - initial release
// ============================================================================
module ahb_lite_bus_arbiter #(
  parameter int BUS_WIDTH      = 32,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_BEATS      = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HBUSREQ0,
  input  logic                 HBUSREQ1,
  output logic                 HGRANT0,
  output logic                 HGRANT1,
  input  logic [BUS_WIDTH-1:0] M0_HADDR,
  input  logic [1:0]           M0_HTRANS,
  input  logic                 M0_HWRITE,
  input  logic [2:0]           M0_HSIZE,
  input  logic [2:0]           M0_HBURST,
  input  logic [3:0]           M0_HPROT,
  input  logic                 M0_HMASTLOCK,
  input  logic [BUS_WIDTH-1:0] M0_HWDATA,
  input  logic [BUS_WIDTH-1:0] M1_HADDR,
  input  logic [1:0]           M1_HTRANS,
  input  logic                 M1_HWRITE,
  input  logic [2:0]           M1_HSIZE,
  input  logic [2:0]           M1_HBURST,
  input  logic [3:0]           M1_HPROT,
  input  logic                 M1_HMASTLOCK,
  input  logic [BUS_WIDTH-1:0] M1_HWDATA,
  output logic [BUS_WIDTH-1:0] S_HADDR,
  output logic [1:0]           S_HTRANS,
  output logic                 S_HWRITE,
  output logic [2:0]           S_HSIZE,
  output logic [2:0]           S_HBURST,
  output logic [3:0]           S_HPROT,
  output logic                 S_HMASTLOCK,
  output logic [BUS_WIDTH-1:0] S_HWDATA,
  input  logic                 HREADY,
  output logic                 HMASTER,
  output logic                 HMASTER_D
);

  localparam logic       DEF_M      = (DEFAULT_MASTER != 0);
  localparam logic [7:0] MAX_B      = 8'(MAX_BEATS);
  localparam logic [1:0] TR_IDLE    = 2'b00;
  localparam logic [1:0] TR_NONSEQ  = 2'b10;
  localparam logic [1:0] TR_SEQ     = 2'b11;
  localparam logic [2:0] BST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    PARK = 2'd0,
    OWN  = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       grant_q, grant_d;
  logic       hmaster_q, hmaster_d;
  logic       hmaster_d_q, hmaster_d_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic       contend;
  logic       tie_winner;

  // Arbitration decisions look at the granted master's request and control.
  logic       own_req, oth_req, own_lock, beat_expire, ap;
  logic [1:0] own_trans;
  logic [2:0] own_burst;

  assign own_req   = grant_q ? HBUSREQ1     : HBUSREQ0;
  assign oth_req   = grant_q ? HBUSREQ0     : HBUSREQ1;
  assign own_lock  = grant_q ? M1_HMASTLOCK : M0_HMASTLOCK;
  assign own_trans = grant_q ? M1_HTRANS    : M0_HTRANS;
  assign own_burst = grant_q ? M1_HBURST    : M0_HBURST;

`ifdef AHB_ARB_FIXED_PRIO_EN
  assign tie_winner  = 1'b0;
  assign beat_expire = grant_q && (beat_cnt_q >= MAX_B);
`else
  logic rr_q, rr_d;

  assign tie_winner  = ~rr_q;
  assign beat_expire = (beat_cnt_q >= MAX_B);

  always_comb begin
    rr_d = rr_q;
    if (contend) rr_d = grant_d;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) rr_q <= DEF_M;
    else          rr_q <= rr_d;
  end
`endif

  assign ap = HREADY && !own_lock &&
              ((own_trans == TR_IDLE) || !own_req ||
               ((own_trans == TR_NONSEQ) && (own_burst == BST_SINGLE)) ||
               (beat_expire && (own_trans == TR_NONSEQ)));

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    hmaster_d   = hmaster_q;
    hmaster_d_d = hmaster_d_q;
    beat_cnt_d  = beat_cnt_q;
    contend     = 1'b0;
    if (HREADY) begin
      hmaster_d   = grant_q;
      hmaster_d_d = hmaster_q;
      if (oth_req && ((own_trans == TR_NONSEQ) || (own_trans == TR_SEQ)) &&
          (beat_cnt_q != 8'hFF))
        beat_cnt_d = beat_cnt_q + 8'd1;
      case (state_q)
        PARK: begin
          if (HBUSREQ0 && HBUSREQ1) begin
            state_d = OWN;
            grant_d = tie_winner;
            contend = 1'b1;
          end else if (HBUSREQ0 || HBUSREQ1) begin
            state_d = OWN;
            grant_d = HBUSREQ1;
          end
        end
        OWN: begin
          // A locked owner freezes the grant even if the beat budget is spent.
          if (own_lock) begin
            state_d = LOCK;
          end else if (ap) begin
            if (oth_req) begin
              grant_d = ~grant_q;
              contend = 1'b1;
            end else if (!own_req) begin
              state_d = PARK;
              grant_d = DEF_M;
            end
          end
        end
        LOCK: begin
          if (!own_lock) state_d = OWN;
        end
        default: state_d = PARK;
      endcase
      if (grant_d != grant_q) beat_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= PARK;
      grant_q     <= DEF_M;
      hmaster_q   <= DEF_M;
      hmaster_d_q <= DEF_M;
      beat_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      hmaster_q   <= hmaster_d;
      hmaster_d_q <= hmaster_d_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign HGRANT0   = ~grant_q;
  assign HGRANT1   = grant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTER_D = hmaster_d_q;

  // Address phase follows HMASTER; a parked bus never issues a transfer.
  assign S_HADDR     = hmaster_q ? M1_HADDR     : M0_HADDR;
  assign S_HTRANS    = (state_q == PARK) ? TR_IDLE : (hmaster_q ? M1_HTRANS : M0_HTRANS);
  assign S_HWRITE    = hmaster_q ? M1_HWRITE    : M0_HWRITE;
  assign S_HSIZE     = hmaster_q ? M1_HSIZE     : M0_HSIZE;
  assign S_HBURST    = hmaster_q ? M1_HBURST    : M0_HBURST;
  assign S_HPROT     = hmaster_q ? M1_HPROT     : M0_HPROT;
  assign S_HMASTLOCK = hmaster_q ? M1_HMASTLOCK : M0_HMASTLOCK;
  assign S_HWDATA    = hmaster_d_q ? M1_HWDATA  : M0_HWDATA;

endmodule
`default_nettype wire
